// File: rtl/tx_response_scheduler.sv
// Response byte scheduler for the UART TX path.
// Queues RF (1 byte) and ALU (2 byte) responses in a small byte FIFO and hands them one at a
// time to the UART TX through a level valid / busy handshake with a busy-rise timeout.
module tx_response_scheduler #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [WIDTH-1:0]              rf_rd_data_in,
  input  logic                          rf_rd_data_valid_in,
  input  logic [2*WIDTH-1:0]            alu_data_in,
  input  logic                          alu_data_valid_in,
  input  logic                          uart_tx_busy_in,
  output logic [WIDTH-1:0]              uart_tx_data_out,
  output logic                          uart_tx_data_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          fifo_full_out,
  output logic                          drop_out,
  output logic                          timeout_out,
  output logic                          idle_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [LvlW-1:0] DepthL  = LvlW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] TmoLast = CntW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitLo} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [CntW-1:0] tmo_cnt_q;
  logic [WIDTH-1:0] data_q;
  logic            valid_q;
  logic            timeout_q;
  logic            drop_q;

  logic            pop;
  logic [LvlW-1:0] free_slots;
  logic [LvlW-1:0] free_after_alu;
  logic            alu_ok;
  logic            rf_ok;
  logic            drop_d;
  logic [1:0]      push_cnt;
  logic [PtrW-1:0] alu_hi_ptr;
  logic [PtrW-1:0] rf_ptr;

  // Head leaves the FIFO when the request ends, either by busy rising or by timeout.
  assign pop = (state_q == StReq) && (uart_tx_busy_in || (tmo_cnt_q == TmoLast));

  // Enqueue admission: ALU word is all-or-nothing and takes priority over the RF byte.
  always_comb begin
    free_slots     = DepthL - level_q + LvlW'(pop);
    alu_ok         = alu_data_valid_in && (free_slots >= LvlW'(2));
    free_after_alu = alu_ok ? (free_slots - LvlW'(2)) : free_slots;
    rf_ok          = rf_rd_data_valid_in && (free_after_alu >= LvlW'(1));
    drop_d         = (alu_data_valid_in && !alu_ok) || (rf_rd_data_valid_in && !rf_ok);
    push_cnt       = (alu_ok ? 2'd2 : 2'd0) + (rf_ok ? 2'd1 : 2'd0);
    alu_hi_ptr     = wr_ptr_q + PtrW'(1);
    rf_ptr         = alu_ok ? (wr_ptr_q + PtrW'(2)) : wr_ptr_q;
    wr_ptr_d       = wr_ptr_q + PtrW'(push_cnt);
    rd_ptr_d       = rd_ptr_q + PtrW'(pop);
    level_d        = level_q - LvlW'(pop) + LvlW'(push_cnt);
  end

  // Byte storage: ALU LSB, then MSB, then the RF byte.
  always_ff @(posedge clk) begin
    if (alu_ok) begin
      mem_q[wr_ptr_q]   <= alu_data_in[WIDTH-1:0];
      mem_q[alu_hi_ptr] <= alu_data_in[2*WIDTH-1:WIDTH];
    end
    if (rf_ok) begin
      mem_q[rf_ptr] <= rf_rd_data_in;
    end
  end

  // FIFO pointers, level and drop pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Handshake FSM with registered data, valid and timeout pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (level_q != '0) begin
            data_q    <= mem_q[rd_ptr_q];
            valid_q   <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (pop) begin
            valid_q   <= 1'b0;
            timeout_q <= !uart_tx_busy_in;
            state_q   <= StWaitLo;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          end
        end
        StWaitLo: begin
          if (!uart_tx_busy_in) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx_data_out       = data_q;
  assign uart_tx_data_valid_out = valid_q;
  assign fifo_level_out         = level_q;
  assign fifo_full_out          = (level_q == DepthL);
  assign drop_out               = drop_q;
  assign timeout_out            = timeout_q;
  assign idle_out               = (level_q == '0) && (state_q == StIdle);

endmodule

// File: tb/tb_tx_response_scheduler.sv
// Bench for tx_response_scheduler: directed scenarios plus random traffic, compared every cycle
// against a queue-based transaction model.
module tb_tx_response_scheduler;

  localparam int W   = 8;
  localparam int DEP = 4;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  rf_rd_data_in;
  logic          rf_rd_data_valid_in;
  logic [2*W-1:0] alu_data_in;
  logic          alu_data_valid_in;
  logic          uart_tx_busy_in;
  logic [W-1:0]  uart_tx_data_out;
  logic          uart_tx_data_valid_out;
  logic [2:0]    fifo_level_out;
  logic          fifo_full_out;
  logic          drop_out;
  logic          timeout_out;
  logic          idle_out;

  tx_response_scheduler #(
    .WIDTH       (W),
    .FIFO_DEPTH  (DEP),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .rf_rd_data_in         (rf_rd_data_in),
    .rf_rd_data_valid_in   (rf_rd_data_valid_in),
    .alu_data_in           (alu_data_in),
    .alu_data_valid_in     (alu_data_valid_in),
    .uart_tx_busy_in       (uart_tx_busy_in),
    .uart_tx_data_out      (uart_tx_data_out),
    .uart_tx_data_valid_out(uart_tx_data_valid_out),
    .fifo_level_out        (fifo_level_out),
    .fifo_full_out         (fifo_full_out),
    .drop_out              (drop_out),
    .timeout_out           (timeout_out),
    .idle_out              (idle_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queued bytes plus the state of the current request.
  byte unsigned mq[$];
  bit   m_valid, m_drop, m_tmo;
  byte unsigned m_data;
  int   m_mode;  // 0 nothing in flight, 1 requesting, 2 waiting for busy to fall
  int   m_age;   // cycles the current request has been outstanding

  // UART emulator and observation trackers.
  int busy_mode = 0;      // 0 emulate, 1 force high, 2 force low
  int em_delay_cfg = -1;  // -1: random response delay
  int em_hold_cfg = -1;   // -1: random busy duration
  int em_seen = 0, em_target = 0, em_hold = 0;
  int vrun = 0, last_run = 0, peak = 0, tmo_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(uart_tx_data_valid_out), 32'(m_valid));
    check_eq("data", 32'(uart_tx_data_out), 32'(m_data));
    check_eq("level", 32'(fifo_level_out), 32'(mq.size()));
    check_eq("full", 32'(fifo_full_out), 32'(mq.size() == DEP));
    check_eq("drop", 32'(drop_out), 32'(m_drop));
    check_eq("timeout", 32'(timeout_out), 32'(m_tmo));
    check_eq("idle", 32'(idle_out), 32'(mq.size() == 0 && m_mode == 0));
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_drop = 0; m_tmo = 0; m_data = 0; m_mode = 0; m_age = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge model state.
  task automatic model_step(input bit rv, input byte unsigned rd, input bit av,
                            input logic [15:0] ad, input bit busy);
    int  sz;
    int  free;
    bit  pop, a_ok, r_ok;
    sz   = mq.size();
    pop  = (m_mode == 1) && (busy || m_age == TMO - 1);
    free = DEP - sz + int'(pop);
    a_ok = av && (free >= 2);
    r_ok = rv && ((free - (a_ok ? 2 : 0)) >= 1);
    m_drop = (av && !a_ok) || (rv && !r_ok);
    m_tmo  = 0;
    case (m_mode)
      0: if (sz > 0) begin m_data = mq[0]; m_valid = 1; m_age = 0; m_mode = 1; end
      1: if (pop) begin m_valid = 0; m_tmo = !busy; m_mode = 2; end
         else m_age++;
      default: if (!busy) m_mode = 0;
    endcase
    if (pop) void'(mq.pop_front());
    if (a_ok) begin mq.push_back(ad[7:0]); mq.push_back(ad[15:8]); end
    if (r_ok) mq.push_back(rd);
  endtask

  task automatic drive_busy();
    if (busy_mode == 1) uart_tx_busy_in = 1'b1;
    else if (busy_mode == 2) uart_tx_busy_in = 1'b0;
    else if (uart_tx_busy_in) begin
      if (em_hold == 0) uart_tx_busy_in = 1'b0;
      else em_hold--;
    end else if (uart_tx_data_valid_out) begin
      if (em_seen == em_target) begin
        uart_tx_busy_in = 1'b1;
        em_hold = (em_hold_cfg >= 0) ? em_hold_cfg : int'($urandom_range(0, 8));
      end
      em_seen++;
    end else begin
      em_seen = 0;
      if (em_delay_cfg >= 0) em_target = em_delay_cfg;
      else em_target = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
    end
  endtask

  // Called at a negedge: check, drive next inputs, advance model, wait one cycle.
  task automatic step(input bit rv, input byte unsigned rd, input bit av, input logic [15:0] ad);
    check_outputs();
    if (uart_tx_data_valid_out) vrun++;
    else if (vrun > 0) begin last_run = vrun; vrun = 0; end
    if (int'(fifo_level_out) > peak) peak = int'(fifo_level_out);
    if (timeout_out) tmo_seen++;
    drive_busy();
    rf_rd_data_valid_in = rv;
    rf_rd_data_in       = rd;
    alu_data_valid_in   = av;
    alu_data_in         = ad;
    model_step(rv, rd, av, ad, uart_tx_busy_in);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 16'h0000);
  endtask

  initial begin
    reset_n = 1'b0;
    rf_rd_data_in = '0; rf_rd_data_valid_in = 1'b0;
    alu_data_in = '0; alu_data_valid_in = 1'b0;
    uart_tx_busy_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // RF 0xA5, busy rises on the 6th valid cycle and stays high for 40 cycles.
    em_delay_cfg = 5; em_hold_cfg = 39;
    step(1, 8'hA5, 0, 16'h0000);
    idle_cycles(60);
    check_eq("a5_valid_len", 32'(last_run), 32'd6);
    check_eq("a5_idle", 32'(idle_out), 32'd1);

    // ALU 0x1234 -> 0x34 then 0x12.
    em_delay_cfg = 2; em_hold_cfg = 3;
    step(0, 8'h00, 1, 16'h1234);
    idle_cycles(30);

    // Simultaneous RF and ALU into an empty FIFO; level peaks at 3.
    peak = 0;
    step(1, 8'h11, 1, 16'hBEEF);
    idle_cycles(40);
    check_eq("peak_level", 32'(peak), 32'd3);

    // Busy never rises: each byte times out after exactly TMO valid cycles.
    busy_mode = 2; tmo_seen = 0;
    step(0, 8'h00, 1, 16'h5566);
    idle_cycles(60);
    check_eq("tmo_valid_len", 32'(last_run), 32'(TMO));
    check_eq("tmo_pulses", 32'(tmo_seen), 32'd2);

    // Busy stuck high: fill to 3, ALU dropped, then RF fills the FIFO.
    busy_mode = 1;
    step(1, 8'h11, 1, 16'hBEEF);
    idle_cycles(2);
    step(1, 8'h22, 0, 16'h0000);
    step(0, 8'h00, 1, 16'hABCD);
    check_eq("drop_pulse", 32'(drop_out), 32'd1);
    check_eq("level_after_drop", 32'(fifo_level_out), 32'd3);
    step(1, 8'h33, 0, 16'h0000);
    check_eq("full_after_rf", 32'(fifo_full_out), 32'd1);
    idle_cycles(2);
    busy_mode = 0; em_hold = 2; em_delay_cfg = -1; em_hold_cfg = -1;
    idle_cycles(80);

    // Asynchronous reset while requesting with 2 bytes queued.
    busy_mode = 2;
    step(0, 8'h00, 1, 16'hCAFE);
    idle_cycles(2);
    check_eq("pre_rst_valid", 32'(uart_tx_data_valid_out), 32'd1);
    check_eq("pre_rst_level", 32'(fifo_level_out), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(uart_tx_data_valid_out), 32'd0);
    check_eq("rst_level", 32'(fifo_level_out), 32'd0);
    check_eq("rst_idle", 32'(idle_out), 32'd1);
    model_reset();
    vrun = 0;
    @(negedge clk);
    reset_n = 1'b1;
    busy_mode = 0; em_seen = 0; em_delay_cfg = 3; em_hold_cfg = 4;
    step(1, 8'h5A, 0, 16'h0000);
    idle_cycles(30);

    // Random traffic against the model.
    em_delay_cfg = -1; em_hold_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) == 0, 16'($urandom));
    end
    idle_cycles(300);
    check_eq("final_idle", 32'(idle_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
